transform_arbiter: RTL and testbench

//  Shares one transform_primary instance between two sample streams (e.g. two

---
 rtl/transform_arbiter.sv | 177 +++++++++++++++++
 tb/tb_transform_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/transform_arbiter.sv
// transform_arbiter: block-granular round-robin sharing of one transform
// between two sample streams. A tag FIFO remembers which requester owns
// each block in flight so transform results are routed back to it.
module transform_arbiter #(
    parameter int WIDTH  = 16,
    parameter int LENGTH = 64,
    parameter int DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 s0_valid,
    output logic                 s0_ready,
    input  logic [2*WIDTH-1:0]   s0_data,
    input  logic                 s1_valid,
    output logic                 s1_ready,
    input  logic [2*WIDTH-1:0]   s1_data,
    output logic                 t_valid,
    input  logic                 t_ready,
    output logic [2*WIDTH-1:0]   t_data,
    input  logic                 r_valid,
    output logic                 r_ready,
    input  logic [2*WIDTH+1:0]   r_data,
    output logic                 m0_valid,
    input  logic                 m0_ready,
    output logic [2*WIDTH+1:0]   m0_data,
    output logic                 m1_valid,
    input  logic                 m1_ready,
    output logic [2*WIDTH+1:0]   m1_data
);
    localparam int CW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LAST  = CW'(LENGTH - 1);
    localparam logic [PW-1:0] PLAST = PW'(DEPTH - 1);
    localparam logic [OW-1:0] OFULL = OW'(DEPTH);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_e;

    logic [1:0]       rst_sync_q;
    logic             rst_n_int;
    state_e           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [CW-1:0]    icnt_q, icnt_d;
    logic [CW-1:0]    ocnt_q, ocnt_d;
    logic [DEPTH-1:0] tags_q;
    logic [PW-1:0]    wr_q, rd_q;
    logic [OW-1:0]    occ_q, occ_d;
    logic             push, push_tag, pop, sel;
    logic             fifo_full, fifo_empty, head_tag;

    // Assert immediately, release on a clock edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_int = rst_sync_q[1];

    // Full/empty come from registered occupancy, so a same-cycle pop does not
    // unblock a grant until the following cycle.
    assign fifo_full  = (occ_q == OFULL);
    assign fifo_empty = (occ_q == '0);
    assign head_tag   = tags_q[rd_q];
    assign m0_data    = r_data;
    assign m1_data    = r_data;

    // Input FSM: pick a requester in IDLE, then pass its stream for one block
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        icnt_d   = icnt_q;
        push     = 1'b0;
        push_tag = 1'b0;
        sel      = 1'b0;
        t_valid  = 1'b0;
        t_data   = '0;
        s0_ready = 1'b0;
        s1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_full && (s0_valid || s1_valid)) begin
                    sel      = (s0_valid && s1_valid) ? ptr_q : s1_valid;
                    push     = 1'b1;
                    push_tag = sel;
                    icnt_d   = '0;
                    state_d  = sel ? GRANT1 : GRANT0;
                end
            end
            GRANT0: begin
                t_valid  = s0_valid;
                t_data   = s0_data;
                s0_ready = t_ready;
                if (s0_valid && t_ready) begin
                    if (icnt_q == LAST) begin
                        icnt_d  = '0;
                        ptr_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        icnt_d = icnt_q + 1'b1;
                    end
                end
            end
            GRANT1: begin
                t_valid  = s1_valid;
                t_data   = s1_data;
                s1_ready = t_ready;
                if (s1_valid && t_ready) begin
                    if (icnt_q == LAST) begin
                        icnt_d  = '0;
                        ptr_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        icnt_d = icnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output side: head tag steers the transform result to its owner
    always_comb begin
        pop      = 1'b0;
        ocnt_d   = ocnt_q;
        r_ready  = 1'b0;
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        if (!fifo_empty) begin
            if (head_tag) begin
                m1_valid = r_valid;
                r_ready  = m1_ready;
            end else begin
                m0_valid = r_valid;
                r_ready  = m0_ready;
            end
            if (r_valid && r_ready) begin
                if (ocnt_q == LAST) begin
                    pop    = 1'b1;
                    ocnt_d = '0;
                end else begin
                    ocnt_d = ocnt_q + 1'b1;
                end
            end
        end
    end

    assign occ_d = occ_q + OW'(push) - OW'(pop);

    // State, counters and tag FIFO
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            icnt_q  <= '0;
            ocnt_q  <= '0;
            tags_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            icnt_q  <= icnt_d;
            ocnt_q  <= ocnt_d;
            occ_q   <= occ_d;
            if (push) begin
                tags_q[wr_q] <= push_tag;
                wr_q         <= (wr_q == PLAST) ? '0 : wr_q + 1'b1;
            end
            if (pop) rd_q <= (rd_q == PLAST) ? '0 : rd_q + 1'b1;
        end
    end

    // A result with no owning block in flight means the transform misbehaved
    a_no_orphan_result: assert property (@(posedge clk) disable iff (!rst_n_int)
        !(r_valid && fifo_empty));

endmodule

// File: tb/tb_transform_arbiter.sv
module tb_transform_arbiter;
    localparam int W  = 8;
    localparam int L  = 16;
    localparam int D  = 2;
    localparam int SW = 2 * W;
    localparam int RW = 2 * W + 2;

    logic          clk, reset_n;
    logic          s0_valid, s0_ready, s1_valid, s1_ready;
    logic [SW-1:0] s0_data, s1_data, t_data;
    logic          t_valid, t_ready, r_valid, r_ready;
    logic [RW-1:0] r_data, m0_data, m1_data;
    logic          m0_valid, m0_ready, m1_valid, m1_ready;

    transform_arbiter #(.WIDTH(W), .LENGTH(L), .DEPTH(D)) dut (
        .clk(clk), .reset_n(reset_n),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_data(s0_data),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_data(s1_data),
        .t_valid(t_valid), .t_ready(t_ready), .t_data(t_data),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_data(m0_data),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_data(m1_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors = 0;
    int miscompares = 0;

    // Bench-side model: source queues, fake transform queue, per-requester
    // expected results, and the expected owner of each upcoming block.
    logic [SW-1:0] src0[$], src1[$];
    logic [RW-1:0] xq[$], exp0[$], exp1[$];
    bit            gexp[$];
    int  bbeat, tbeats, m0beats, m1beats, gap_cnt;
    bit  gap_en, blk_end, gap_check, exact_gap, quiet_m1, mr0;

    function automatic logic [RW-1:0] sext(input logic [SW-1:0] s);
        return {s[SW-1], s[SW-1:W], s[W-1], s[W-1:0]};
    endfunction

    function automatic logic [SW-1:0] pat(input int n, input int salt);
        return {8'(n * 37 + salt), 8'(n ^ (8'hA5 + salt))};
    endfunction

    function automatic bit model_idle();
        return src0.size() == 0 && src1.size() == 0 && xq.size() == 0 &&
               exp0.size() == 0 && exp1.size() == 0 && gexp.size() == 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        src0.delete(); src1.delete(); xq.delete(); exp0.delete(); exp1.delete();
        gexp.delete();
        bbeat = 0; tbeats = 0; m0beats = 0; m1beats = 0; gap_cnt = 0;
        gap_en = 0; blk_end = 0; gap_check = 0; exact_gap = 0; quiet_m1 = 0; mr0 = 1;
    endtask

    task automatic check_all_quiet(input string tag);
        chk({tag, "_s0rdy"}, 64'(s0_ready), 64'd0);
        chk({tag, "_s1rdy"}, 64'(s1_ready), 64'd0);
        chk({tag, "_tvld"},  64'(t_valid),  64'd0);
        chk({tag, "_rrdy"},  64'(r_ready),  64'd0);
        chk({tag, "_m0vld"}, 64'(m0_valid), 64'd0);
        chk({tag, "_m1vld"}, 64'(m1_valid), 64'd0);
    endtask

    task automatic do_reset(input bit check);
        @(negedge clk);
        reset_n  = 1'b0;
        clear_model();
        s0_valid = 1'b1; s1_valid = 1'b1;
        r_valid  = 1'b0;
        t_ready  = 1'b1; m0_ready = 1'b1; m1_ready = 1'b1;
        #1;
        if (check) check_all_quiet("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One cycle: drive at negedge, evaluate handshakes after settling
    task automatic tick();
        logic a0, a1, at, ar, am0, am1;
        bit o;
        logic [SW-1:0] smp;
        logic [RW-1:0] e;
        @(negedge clk);
        s0_valid = (src0.size() > 0) && (gap_cnt == 0);
        s0_data  = (src0.size() > 0) ? src0[0] : '0;
        if (gap_cnt > 0) gap_cnt--;
        s1_valid = src1.size() > 0;
        s1_data  = (src1.size() > 0) ? src1[0] : '0;
        r_valid  = xq.size() > 0;
        r_data   = (xq.size() > 0) ? xq[0] : '0;
        t_ready  = 1'b1; m0_ready = mr0; m1_ready = 1'b1;
        #1;
        a0 = s0_valid && s0_ready; a1 = s1_valid && s1_ready;
        at = t_valid && t_ready;   ar = r_valid && r_ready;
        am0 = m0_valid && m0_ready; am1 = m1_valid && m1_ready;
        if (gap_check) begin
            chk("gap_exact", 64'(t_valid), 64'd1);
            gap_check = 0;
        end
        if (blk_end) begin
            chk("bubble", 64'(t_valid), 64'd0);
            blk_end = 0;
            if (exact_gap && (s0_valid || s1_valid)) gap_check = 1;
        end
        if (quiet_m1) chk("m1_quiet", 64'(m1_valid), 64'd0);
        if (at) begin
            o = (gexp.size() > 0) ? gexp[0] : 1'b0;
            chk("src_acc", 64'(a0 ^ a1), 64'd1);
            chk("owner", 64'(a1), 64'(o));
            chk("other_rdy", 64'(o ? s0_ready : s1_ready), 64'd0);
            smp = o ? ((src1.size() > 0) ? src1.pop_front() : 'x)
                    : ((src0.size() > 0) ? src0.pop_front() : 'x);
            chk("t_data", 64'(t_data), 64'(smp));
            xq.push_back(sext(smp));
            if (o) exp1.push_back(sext(smp)); else exp0.push_back(sext(smp));
            if (!o && gap_en) gap_cnt = 2;
            tbeats++; bbeat++;
            if (bbeat == L) begin
                bbeat = 0;
                blk_end = 1;
                if (gexp.size() > 0) void'(gexp.pop_front());
            end
        end
        chk("m_excl", 64'(m0_valid && m1_valid), 64'd0);
        chk("r_route", 64'(ar), 64'(am0 | am1));
        if (ar && xq.size() > 0) void'(xq.pop_front());
        if (am0) begin
            e = (exp0.size() > 0) ? exp0.pop_front() : 'x;
            chk("m0_data", 64'(m0_data), 64'(e));
            m0beats++;
        end
        if (am1) begin
            e = (exp1.size() > 0) ? exp1.pop_front() : 'x;
            chk("m1_data", 64'(m1_data), 64'(e));
            m1beats++;
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (!model_idle() && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(model_idle()), 64'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        s0_valid = 0; s1_valid = 0; s0_data = '0; s1_data = '0;
        t_ready = 1; r_valid = 0; r_data = '0; m0_ready = 1; m1_ready = 1;
        clear_model();

        // Only s0, two blocks, result to m0 only, single bubble between blocks
        do_reset(1);
        for (int n = 0; n < 2 * L; n++) src0.push_back(pat(n, 0));
        gexp = '{0, 0};
        exact_gap = 1; quiet_m1 = 1;
        drain("t1_done", 400);
        chk("t1_m0beats", 64'(m0beats), 64'(2 * L));
        chk("t1_m1beats", 64'(m1beats), 64'd0);

        // Both valid from reset: grants alternate starting at 0
        do_reset(0);
        for (int n = 0; n < 2 * L; n++) begin
            src0.push_back(pat(n, 3));
            src1.push_back(pat(n, 90));
        end
        gexp = '{0, 1, 0, 1};
        drain("t2_done", 600);
        chk("t2_m0beats", 64'(m0beats), 64'(2 * L));
        chk("t2_m1beats", 64'(m1beats), 64'(2 * L));

        // Results back-pressured: only DEPTH blocks granted, then stall
        do_reset(0);
        for (int n = 0; n < (D + 1) * L; n++) src0.push_back(pat(n, 17));
        gexp = '{0, 0, 0};
        mr0 = 0; quiet_m1 = 1;
        repeat (80) tick();
        chk("t3_stall_beats", 64'(tbeats), 64'(D * L));
        chk("t3_stall_tvalid", 64'(t_valid), 64'd0);
        chk("t3_stall_m0", 64'(m0beats), 64'd0);
        mr0 = 1;
        drain("t3_done", 600);
        chk("t3_m0beats", 64'(m0beats), 64'((D + 1) * L));

        // Gapped s0 with s1 waiting: the block is never split
        do_reset(0);
        for (int n = 0; n < L; n++) begin
            src0.push_back(pat(n, 55));
            src1.push_back(pat(n, 200));
        end
        gexp = '{0, 1};
        gap_en = 1;
        drain("t4_done", 600);
        chk("t4_m0beats", 64'(m0beats), 64'(L));
        chk("t4_m1beats", 64'(m1beats), 64'(L));

        // Reset in the middle of a block, then a clean restart
        do_reset(0);
        for (int n = 0; n < L; n++) src0.push_back(pat(n, 9));
        gexp = '{0};
        begin
            int n = 0;
            while (bbeat < 10 && n < 100) begin
                tick();
                n++;
            end
        end
        chk("t5_reach_beat10", 64'(bbeat), 64'd10);
        @(negedge clk);
        reset_n = 1'b0;
        r_valid = 1'b0;
        #1;
        check_all_quiet("t5_midrst");
        clear_model();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int n = 0; n < L; n++) begin
            src0.push_back(pat(n, 77));
            src1.push_back(pat(n, 33));
        end
        gexp = '{0, 1};
        drain("t5_done", 600);
        chk("t5_m0beats", 64'(m0beats), 64'(L));
        chk("t5_m1beats", 64'(m1beats), 64'(L));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
